mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the IF fetch port and the MEM-stage data port of the 5-stage pipeline.
- Sequences fixed-latency memory accesses and grants the data port priority.
- Drives the stall_if and stall_mem hold requests that the hazard/stall logic ORs into en_IF, en_IFID and the pipeline register enables.
- A branch/jump flush cancels an in-flight fetch without aborting the memory cycle.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: fetch port, data port, shared memory bus and stall requests.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the IF fetch port and the MEM data port.
// Data port has priority; a flushed fetch still occupies the memory but returns nothing.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, BUSY}     state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              store_q, store_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              d_elig, i_elig, grant;

    always_comb begin
        // A port whose ready pulse is up this cycle is still presenting the finished request.
        d_elig      = bus.dm_req & ~dm_ready_q;
        i_elig      = bus.if_req & ~if_ready_q & ~bus.if_flush;
        grant       = 1'b0;
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        cancel_d    = cancel_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                grant    = d_elig | i_elig;
                if (d_elig) begin
                    owner_d     = OWN_DM;
                    store_d     = bus.dm_we;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                end else if (i_elig) begin
                    owner_d     = OWN_IF;
                    store_d     = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                end
                if (grant) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (owner_q == OWN_IF && bus.if_flush) cancel_d = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_ready_d = 1'b1;
                        if (!store_q) dm_rdata_d = bus.mem_rdata;
                    end else if (!(cancel_q | bus.if_flush)) begin
                        // a flush landing on the return cycle still suppresses the fetch
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            store_q     <= 1'b0;
            cancel_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            cancel_q    <= cancel_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Combinational outputs are forced low while reset is held so the bus is quiet at once.
    assign bus.mem_en    = rst_n & grant;
    assign bus.mem_we    = rst_n & mem_we_d;
    assign bus.mem_addr  = rst_n ? mem_addr_d : '0;
    assign bus.mem_wdata = rst_n ? mem_wdata_d : '0;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.stall_mem = rst_n & bus.dm_req & ~dm_ready_q;
    assign bus.stall_if  = rst_n & ((bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 has MEM_LAT=2, instance 1 has MEM_LAT=1.
// Directed vector table, hand sequences for streaming and async reset, then random traffic vs a model.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        if_req, if_flush, dm_req, dm_we;
        logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    } in_t;

    typedef struct packed {
        logic        mem_en, mem_we;
        logic [31:0] mem_addr, mem_wdata, if_rdata, dm_rdata;
        logic        if_ready, dm_ready, stall_if, stall_mem;
    } out_t;

    typedef struct { in_t i; out_t o; } vec_t;

    // Model state: an access issued in cycle c returns its data in cycle c+lat.
    typedef struct {
        int          lat, ret;
        bit          busy, by_dm, store, cxl, irdy, drdy, lwe;
        logic [31:0] ird, drd, laddr, lwdata;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  drv [2];
    out_t got [2];
    mdl_t m   [2];
    bit   ifdone [2];
    bit   dmdone [2];
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 2 : 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus[g])
        );
        assign bus[g].if_req    = drv[g].if_req;
        assign bus[g].if_addr   = drv[g].if_addr;
        assign bus[g].if_flush  = drv[g].if_flush;
        assign bus[g].dm_req    = drv[g].dm_req;
        assign bus[g].dm_we     = drv[g].dm_we;
        assign bus[g].dm_addr   = drv[g].dm_addr;
        assign bus[g].dm_wdata  = drv[g].dm_wdata;
        assign bus[g].mem_rdata = drv[g].mem_rdata;
        assign got[g] = {bus[g].mem_en, bus[g].mem_we, bus[g].mem_addr, bus[g].mem_wdata,
                         bus[g].if_rdata, bus[g].dm_rdata, bus[g].if_ready, bus[g].dm_ready,
                         bus[g].stall_if, bus[g].stall_mem};
    end

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic fl, logic dr, logic we,
                                  logic [31:0] da, logic [31:0] wd, logic [31:0] rd);
        in_t v;
        v = '{if_req: ir, if_flush: fl, dm_req: dr, dm_we: we,
              if_addr: ia, dm_addr: da, dm_wdata: wd, mem_rdata: rd};
        return v;
    endfunction

    function automatic out_t mk_out(logic en, logic we, logic [31:0] a, logic [31:0] wd,
                                    logic [31:0] ird, logic [31:0] drd, logic irdy, logic drdy,
                                    logic sif, logic smem);
        out_t o;
        o = '{mem_en: en, mem_we: we, mem_addr: a, mem_wdata: wd, if_rdata: ird, dm_rdata: drd,
              if_ready: irdy, dm_ready: drdy, stall_if: sif, stall_mem: smem};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [133:0] g, input logic [133:0] e);
        nvec++;
        if (g !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    // one clock cycle: drive after the rising edge, sample at the falling edge
    task automatic step(input int k, input in_t v);
        @(posedge clk);
        #1 drv[k] = v;
        @(negedge clk);
    endtask

    task automatic mdl_eval(input int k, input in_t i, input int cyc, output out_t e);
        bit irdy_n, drdy_n, issue;
        irdy_n = 1'b0;
        drdy_n = 1'b0;
        issue  = 1'b0;
        e = '0;
        e.if_rdata  = m[k].ird;
        e.dm_rdata  = m[k].drd;
        e.if_ready  = m[k].irdy;
        e.dm_ready  = m[k].drdy;
        e.stall_mem = i.dm_req && !m[k].drdy;
        e.stall_if  = (i.if_req && !m[k].irdy) || e.stall_mem;
        if (!m[k].busy) begin
            if (i.dm_req && !m[k].drdy) begin
                issue = 1'b1; m[k].by_dm = 1'b1; m[k].store = i.dm_we;
                m[k].lwe = i.dm_we; m[k].laddr = i.dm_addr; m[k].lwdata = i.dm_wdata;
            end else if (i.if_req && !m[k].irdy && !i.if_flush) begin
                issue = 1'b1; m[k].by_dm = 1'b0; m[k].store = 1'b0;
                m[k].lwe = 1'b0; m[k].laddr = i.if_addr; m[k].lwdata = '0;
            end
            if (issue) begin
                m[k].busy = 1'b1;
                m[k].ret  = cyc + m[k].lat;
                m[k].cxl  = 1'b0;
            end
        end else begin
            if (!m[k].by_dm && i.if_flush) m[k].cxl = 1'b1;
            if (cyc == m[k].ret) begin
                m[k].busy = 1'b0;
                if (m[k].by_dm) begin
                    drdy_n = 1'b1;
                    if (!m[k].store) m[k].drd = i.mem_rdata;
                end else if (!m[k].cxl) begin
                    irdy_n = 1'b1;
                    m[k].ird = i.mem_rdata;
                end
            end
        end
        e.mem_en    = issue;
        e.mem_we    = m[k].lwe;
        e.mem_addr  = m[k].laddr;
        e.mem_wdata = m[k].lwdata;
        m[k].irdy = irdy_n;
        m[k].drdy = drdy_n;
    endtask

    // Stream n requests on one port; the ready cycle still shows the old request,
    // so the next issue lands lat+2 cycles after the previous one.
    task automatic burst(input int k, input int lat, input bit dm, input int n, input logic [31:0] base);
        int          en_c [$];
        int          rdy_c [$];
        logic [31:0] en_a [$];
        logic [31:0] rdy_d [$];
        int          nf;
        in_t         v;
        nf = 0;
        for (int c = 0; c < n * (lat + 2) + 3; c++) begin
            v = '0;
            v.mem_rdata = 32'hA000_0000 + 32'(c);
            if (nf < n) begin
                if (dm) begin v.dm_req = 1'b1; v.dm_addr = base + 32'(4 * nf); end
                else    begin v.if_req = 1'b1; v.if_addr = base + 32'(4 * nf); end
            end
            step(k, v);
            if (got[k].mem_en) begin en_c.push_back(c); en_a.push_back(got[k].mem_addr); end
            if (dm ? got[k].dm_ready : got[k].if_ready) begin
                rdy_c.push_back(c);
                rdy_d.push_back(dm ? got[k].dm_rdata : got[k].if_rdata);
                nf++;
            end
        end
        chk($sformatf("burst%0d issue count", k), en_c.size(), n);
        chk($sformatf("burst%0d ready count", k), rdy_c.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < en_c.size()) begin
                chk($sformatf("burst%0d issue%0d cycle", k, i), en_c[i], i * (lat + 2));
                chk($sformatf("burst%0d issue%0d addr", k, i), en_a[i], base + 32'(4 * i));
            end
            if (i < rdy_c.size()) begin
                chk($sformatf("burst%0d ready%0d cycle", k, i), rdy_c[i], i * (lat + 2) + lat + 1);
                chk($sformatf("burst%0d ready%0d data", k, i), rdy_d[i],
                    32'hA000_0000 + 32'(i * (lat + 2) + lat));
            end
        end
    endtask

    initial begin
        vec_t tv [$];
        in_t  v;
        out_t e;

        // reset state, with requests present to show the bus stays quiet
        drv[0] = mk_in(1, 'h100, 0, 1, 1, 'h40, 'h55, 0);
        drv[1] = '0;
        @(negedge clk);
        chk("reset dut0", got[0], '0);
        chk("reset dut1", got[1], '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv[0] = '0;

        // single load, then simultaneous fetch + store, then flush while busy and in idle
        tv.push_back('{mk_in(0, 0, 0, 1, 0, 'h40, 0, 0), mk_out(1, 0, 'h40, 0, 0, 0, 0, 0, 1, 1)});
        tv.push_back('{mk_in(0, 0, 0, 1, 0, 'h40, 0, 0), mk_out(0, 0, 'h40, 0, 0, 0, 0, 0, 1, 1)});
        tv.push_back('{mk_in(0, 0, 0, 1, 0, 'h40, 0, 'hDEADBEEF), mk_out(0, 0, 'h40, 0, 0, 0, 0, 0, 1, 1)});
        tv.push_back('{mk_in(0, 0, 0, 1, 0, 'h40, 0, 0), mk_out(0, 0, 'h40, 0, 0, 'hDEADBEEF, 0, 1, 0, 0)});
        tv.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h40, 0, 0, 'hDEADBEEF, 0, 0, 0, 0)});
        tv.push_back('{mk_in(1, 'h100, 0, 1, 1, 'h80, 'h12345678, 0), mk_out(1, 1, 'h80, 'h12345678, 0, 'hDEADBEEF, 0, 0, 1, 1)});
        tv.push_back('{mk_in(1, 'h100, 0, 1, 1, 'h80, 'h12345678, 0), mk_out(0, 1, 'h80, 'h12345678, 0, 'hDEADBEEF, 0, 0, 1, 1)});
        tv.push_back('{mk_in(1, 'h100, 0, 1, 1, 'h80, 'h12345678, 'h77), mk_out(0, 1, 'h80, 'h12345678, 0, 'hDEADBEEF, 0, 0, 1, 1)});
        tv.push_back('{mk_in(1, 'h100, 0, 1, 1, 'h80, 'h12345678, 0), mk_out(1, 0, 'h100, 0, 0, 'hDEADBEEF, 0, 1, 1, 0)});
        tv.push_back('{mk_in(1, 'h100, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h100, 0, 0, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h100, 0, 0, 0, 0, 0, 'hCAFEF00D), mk_out(0, 0, 'h100, 0, 0, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h100, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h100, 0, 'hCAFEF00D, 'hDEADBEEF, 1, 0, 0, 0)});
        tv.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h100, 0, 'hCAFEF00D, 'hDEADBEEF, 0, 0, 0, 0)});
        tv.push_back('{mk_in(1, 'h300, 0, 0, 0, 0, 0, 0), mk_out(1, 0, 'h300, 0, 'hCAFEF00D, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h200, 1, 0, 0, 0, 0, 0), mk_out(0, 0, 'h300, 0, 'hCAFEF00D, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h200, 0, 0, 0, 0, 0, 'hBAD0BAD0), mk_out(0, 0, 'h300, 0, 'hCAFEF00D, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h200, 0, 0, 0, 0, 0, 0), mk_out(1, 0, 'h200, 0, 'hCAFEF00D, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h200, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h200, 0, 'hCAFEF00D, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h200, 0, 0, 0, 0, 0, 'h0F0F0F0F), mk_out(0, 0, 'h200, 0, 'hCAFEF00D, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h200, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h200, 0, 'h0F0F0F0F, 'hDEADBEEF, 1, 0, 0, 0)});
        tv.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h200, 0, 'h0F0F0F0F, 'hDEADBEEF, 0, 0, 0, 0)});
        tv.push_back('{mk_in(1, 'h204, 1, 0, 0, 0, 0, 0), mk_out(0, 0, 'h200, 0, 'h0F0F0F0F, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h204, 0, 0, 0, 0, 0, 0), mk_out(1, 0, 'h204, 0, 'h0F0F0F0F, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h204, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h204, 0, 'h0F0F0F0F, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h204, 0, 0, 0, 0, 0, 'h11112222), mk_out(0, 0, 'h204, 0, 'h0F0F0F0F, 'hDEADBEEF, 0, 0, 1, 0)});
        tv.push_back('{mk_in(1, 'h204, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h204, 0, 'h11112222, 'hDEADBEEF, 1, 0, 0, 0)});
        tv.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 'h204, 0, 'h11112222, 'hDEADBEEF, 0, 0, 0, 0)});
        foreach (tv[n]) begin
            step(0, tv[n].i);
            chk($sformatf("vec%0d", n), got[0], tv[n].o);
        end

        // continuous fetch of 4 PCs (latency 2), back-to-back loads (latency 1)
        burst(0, 2, 1'b0, 4, 32'h0);
        burst(1, 1, 1'b1, 2, 32'h10);

        // asynchronous reset in the middle of a load
        v = mk_in(0, 0, 0, 1, 0, 'h50, 0, 0);
        step(0, v);
        chk("rst_seq grant", got[0].mem_en, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_seq async clear dut0", got[0], '0);
        chk("rst_seq async clear dut1", got[1], '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        v.dm_addr = 'h60;
        drv[0] = v;
        @(negedge clk);
        chk("rst_seq reissue", {got[0].mem_en, got[0].mem_addr}, {1'b1, 32'h60});
        step(0, v);
        chk("rst_seq no stale ready", got[0].dm_ready, 1'b0);
        v.mem_rdata = 'h5A5A5A5A;
        step(0, v);
        chk("rst_seq wait", got[0].dm_ready, 1'b0);
        v.mem_rdata = 0;
        step(0, v);
        chk("rst_seq ready", {got[0].dm_ready, got[0].dm_rdata}, {1'b1, 32'h5A5A5A5A});

        // random traffic on both instances against the model
        @(posedge clk);
        #1 rst_n = 1'b0;
        drv[0] = '0;
        drv[1] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m[k] = '{default: 0};
            m[k].lat = (k == 0) ? 2 : 1;
            ifdone[k] = 1'b0;
            dmdone[k] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                v = drv[k];
                if (!v.if_req || ifdone[k]) begin
                    v.if_req  = ($urandom_range(0, 2) != 0);
                    v.if_addr = $urandom & ~32'h3;
                end else if ($urandom_range(0, 19) == 0) begin
                    v.if_req = 1'b0;
                end
                if (!v.dm_req || dmdone[k]) begin
                    v.dm_req   = ($urandom_range(0, 2) == 0);
                    v.dm_we    = $urandom_range(0, 1) != 0;
                    v.dm_addr  = $urandom & ~32'h3;
                    v.dm_wdata = $urandom;
                end else if ($urandom_range(0, 19) == 0) begin
                    v.dm_req = 1'b0;
                end
                v.if_flush  = ($urandom_range(0, 7) == 0);
                v.mem_rdata = $urandom;
                ifdone[k] = m[k].irdy;
                dmdone[k] = m[k].drdy;
                drv[k] = v;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                mdl_eval(k, drv[k], c, e);
                chk($sformatf("rand dut%0d cyc%0d", k, c), got[k], e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
